// File: rtl/operand_fwd_unit_pkg.sv
// Shared operand-forwarding definitions: select encodings and default widths.
// The CPU top imports this package as well.
package operand_fwd_unit_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned REG_AW_DEF  = 5;
    localparam int unsigned NUM_SRC_DEF = 2;
    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned SEL_W       = 2;

    typedef enum logic [SEL_W-1:0] {
        SEL_QA   = 2'd0,
        SEL_EXR  = 2'd1,
        SEL_MEMR = 2'd2,
        SEL_MDO  = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/operand_fwd_unit_fwd_src_sel.sv
// Hazard compare and 4:1 operand mux for a single source operand.
// Select and load-hit depend only on pipeline state and the register number.
module fwd_src_sel
    import operand_fwd_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_used,
    input  logic              ex_valid,
    input  logic              ex_wreg,
    input  logic              ex_m2reg,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_valid,
    input  logic              mem_wreg,
    input  logic              mem_m2reg,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] qa,
    input  logic [DATA_W-1:0] ex_r,
    input  logic [DATA_W-1:0] mem_r,
    input  logic [DATA_W-1:0] mem_mdo,
    output logic [SEL_W-1:0]  sel_c,
    output logic [DATA_W-1:0] fwd_c,
    output logic              load_hit_c
);

    logic rs_live;
    logic ex_match;
    logic mem_match;

    // r0 and unread sources never match a producer
    always_comb begin
        rs_live   = rs_used && (rs != '0);
        ex_match  = rs_live && ex_valid && ex_wreg && (ex_rd == rs);
        mem_match = rs_live && mem_valid && mem_wreg && (mem_rd == rs);
    end

    // Youngest producer wins; a load in EX has no data yet and stalls instead
    always_comb begin
        sel_c      = SEL_QA;
        load_hit_c = ex_match && ex_m2reg;
        if (ex_match && !ex_m2reg) begin
            sel_c = SEL_EXR;
        end else if (mem_match) begin
            sel_c = mem_m2reg ? SEL_MDO : SEL_MEMR;
        end
    end

    always_comb begin
        fwd_c = qa;
        case (sel_c)
            SEL_QA:   fwd_c = qa;
            SEL_EXR:  fwd_c = ex_r;
            SEL_MEMR: fwd_c = mem_r;
            SEL_MDO:  fwd_c = mem_mdo;
            default:  fwd_c = qa;
        endcase
    end

endmodule

// File: rtl/operand_fwd_unit.sv
// Operand forwarding and load-use stall detection for a 5-stage pipeline.
// Tracks EX/MEM producer records and counts stall cycles (saturating).
module operand_fwd_unit
    import operand_fwd_unit_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned REG_AW  = REG_AW_DEF,
    parameter int unsigned NUM_SRC = NUM_SRC_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      clrn,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic                      id_wreg,
    input  logic                      id_m2reg,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      flush,
    input  logic [NUM_SRC*DATA_W-1:0] qa,
    input  logic [DATA_W-1:0]         ex_r,
    input  logic [DATA_W-1:0]         mem_r,
    input  logic [DATA_W-1:0]         mem_mdo,
    output logic [NUM_SRC*DATA_W-1:0] fwd_o,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic              wreg;
        logic              m2reg;
        logic [REG_AW-1:0] rd;
    } stage_t;

    stage_t             ex_q;
    stage_t             mem_q;
    stage_t             ex_d;
    logic [NUM_SRC-1:0] load_hit;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_src_sel #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW)
        ) u_sel (
            .rs         (id_rs[k*REG_AW +: REG_AW]),
            .rs_used    (id_rs_used[k]),
            .ex_valid   (ex_q.valid),
            .ex_wreg    (ex_q.wreg),
            .ex_m2reg   (ex_q.m2reg),
            .ex_rd      (ex_q.rd),
            .mem_valid  (mem_q.valid),
            .mem_wreg   (mem_q.wreg),
            .mem_m2reg  (mem_q.m2reg),
            .mem_rd     (mem_q.rd),
            .qa         (qa[k*DATA_W +: DATA_W]),
            .ex_r       (ex_r),
            .mem_r      (mem_r),
            .mem_mdo    (mem_mdo),
            .sel_c      (fwd_sel[k*SEL_W +: SEL_W]),
            .fwd_c      (fwd_o[k*DATA_W +: DATA_W]),
            .load_hit_c (load_hit[k])
        );
    end

    // Flush overrides stall; a stalled or flushed ID slot enters EX as a bubble
    always_comb begin
        stall       = id_valid && !flush && (|load_hit);
        ex_d        = '0;
        ex_d.valid  = id_valid && !stall && !flush;
        ex_d.wreg   = id_wreg;
        ex_d.m2reg  = id_m2reg;
        ex_d.rd     = id_rd;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ex_q      <= '0;
            mem_q     <= '0;
            stall_cnt <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_operand_fwd_unit.sv
// Directed bench for operand_fwd_unit: table-driven pipeline sequence plus
// stall-counter saturation and reset-during-stall sequences.
module tb_operand_fwd_unit;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 5;
    localparam int unsigned NS  = 2;
    localparam int unsigned CW  = 16;
    localparam int unsigned CW2 = 4;
    localparam int          NV  = 17;

    logic              clk = 1'b0;
    logic              clrn;
    logic              id_valid;
    logic [NS*AW-1:0]  id_rs;
    logic [NS-1:0]     id_rs_used;
    logic              id_wreg;
    logic              id_m2reg;
    logic [AW-1:0]     id_rd;
    logic              flush;
    logic [NS*DW-1:0]  qa;
    logic [DW-1:0]     ex_r;
    logic [DW-1:0]     mem_r;
    logic [DW-1:0]     mem_mdo;
    logic [NS*DW-1:0]  fwd_o;
    logic [NS*2-1:0]   fwd_sel;
    logic              stall;
    logic [CW-1:0]     stall_cnt;
    logic [NS*DW-1:0]  fwd_o2;
    logic [NS*2-1:0]   fwd_sel2;
    logic              stall2;
    logic [CW2-1:0]    stall_cnt2;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    operand_fwd_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .CNT_W(CW)) dut (
        .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
        .id_rd(id_rd), .flush(flush), .qa(qa), .ex_r(ex_r), .mem_r(mem_r),
        .mem_mdo(mem_mdo), .fwd_o(fwd_o), .fwd_sel(fwd_sel), .stall(stall),
        .stall_cnt(stall_cnt)
    );

    // Narrow counter copy so saturation is reachable in a short run
    operand_fwd_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .CNT_W(CW2)) dut_sat (
        .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
        .id_rd(id_rd), .flush(flush), .qa(qa), .ex_r(ex_r), .mem_r(mem_r),
        .mem_mdo(mem_mdo), .fwd_o(fwd_o2), .fwd_sel(fwd_sel2), .stall(stall2),
        .stall_cnt(stall_cnt2)
    );

    typedef struct {
        logic [AW-1:0] rs0;
        logic [AW-1:0] rs1;
        logic [1:0]    used;
        logic          valid;
        logic          wreg;
        logic          m2reg;
        logic [AW-1:0] rd;
        logic          fl;
        logic [1:0]    s0;
        logic [1:0]    s1;
        logic          st;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mk(input int rs0, input int rs1, input logic [1:0] used,
                                input logic v, input logic w, input logic m, input int rd,
                                input logic fl, input logic [1:0] s0, input logic [1:0] s1,
                                input logic st, input int cnt);
        vec_t r;
        r.rs0 = AW'(rs0);  r.rs1 = AW'(rs1); r.used = used;
        r.valid = v; r.wreg = w; r.m2reg = m; r.rd = AW'(rd); r.fl = fl;
        r.s0 = s0; r.s1 = s1; r.st = st; r.cnt = CW'(cnt);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] pick(input logic [1:0] s, input int k);
        case (s)
            2'd0:    return qa[k*DW +: DW];
            2'd1:    return ex_r;
            2'd2:    return mem_r;
            default: return mem_mdo;
        endcase
    endfunction

    task automatic drive(input vec_t v, input int i);
        id_rs      = {v.rs1, v.rs0};
        id_rs_used = v.used;
        id_valid   = v.valid;
        id_wreg    = v.wreg;
        id_m2reg   = v.m2reg;
        id_rd      = v.rd;
        flush      = v.fl;
        qa         = {32'h0B0B_0000 + DW'(i), 32'h0A0A_0000 + DW'(i)};
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " stall"}, 64'(stall), 64'(0));
        chk({tag, " sel"}, 64'(fwd_sel), 64'(0));
        chk({tag, " fwd_o"}, 64'(fwd_o), 64'(qa));
        chk({tag, " cnt"}, 64'(stall_cnt), 64'(0));
        chk({tag, " cnt_sat"}, 64'(stall_cnt2), 64'(0));
    endtask

    initial begin
        vec_t lw5;
        // rs0 rs1 used v w m rd fl | s0 s1 st cnt
        tbl[0]  = mk( 1,  2, 2'b11, 1, 1, 0,  3, 0, 0, 0, 0, 0); // add r3
        tbl[1]  = mk( 3,  1, 2'b11, 1, 1, 0,  4, 0, 1, 0, 0, 0); // add r4,r3,r1
        tbl[2]  = mk( 4,  3, 2'b01, 1, 1, 1,  5, 0, 1, 0, 0, 0); // lw r5; rs1 unused
        tbl[3]  = mk( 5,  5, 2'b11, 1, 1, 0,  6, 0, 0, 0, 1, 0); // add r6,r5,r5 stalls
        tbl[4]  = mk( 5,  5, 2'b11, 1, 1, 0,  6, 0, 3, 3, 0, 1); // replay: load in MEM
        tbl[5]  = mk( 0,  0, 2'b11, 1, 1, 0,  7, 0, 0, 0, 0, 1);
        tbl[6]  = mk( 6,  0, 2'b11, 1, 1, 0,  7, 0, 2, 0, 0, 1);
        tbl[7]  = mk( 7,  7, 2'b11, 1, 1, 0,  0, 0, 1, 1, 0, 1); // EX beats MEM
        tbl[8]  = mk( 7,  0, 2'b11, 1, 1, 0,  0, 0, 2, 0, 0, 1);
        tbl[9]  = mk( 0,  0, 2'b11, 1, 1, 1,  8, 0, 0, 0, 0, 1); // r0 producers ignored
        tbl[10] = mk( 8,  8, 2'b01, 1, 1, 0,  9, 1, 0, 0, 0, 1); // flush beats stall
        tbl[11] = mk( 8,  9, 2'b11, 1, 0, 0,  0, 0, 3, 0, 0, 1); // flushed slot is bubble
        tbl[12] = mk( 1,  2, 2'b11, 1, 1, 1, 10, 0, 0, 0, 0, 1);
        tbl[13] = mk(10, 10, 2'b11, 0, 1, 0, 11, 0, 0, 0, 0, 1); // invalid ID: no stall
        tbl[14] = mk(10, 10, 2'b11, 1, 1, 0, 11, 0, 3, 3, 0, 1);
        tbl[15] = mk(10,  0, 2'b01, 1, 1, 1, 12, 0, 0, 0, 0, 1);
        tbl[16] = mk(12,  1, 2'b10, 1, 1, 0, 13, 0, 0, 0, 0, 1); // unused src vs load

        ex_r    = 32'h0000_0011;
        mem_r   = 32'h2222_2222;
        mem_mdo = 32'hDEAD_BEEF;
        clrn    = 1'b0;
        drive(mk(3, 3, 2'b11, 1, 1, 0, 3, 0, 0, 0, 0, 0), 99);
        #12;
        chk_reset_outputs("reset");

        @(posedge clk); #1;
        clrn = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i], i);
            #2;
            chk($sformatf("row%0d sel0", i), 64'(fwd_sel[1:0]), 64'(tbl[i].s0));
            chk($sformatf("row%0d sel1", i), 64'(fwd_sel[3:2]), 64'(tbl[i].s1));
            chk($sformatf("row%0d fwd0", i), 64'(fwd_o[DW-1:0]), 64'(pick(tbl[i].s0, 0)));
            chk($sformatf("row%0d fwd1", i), 64'(fwd_o[2*DW-1:DW]), 64'(pick(tbl[i].s1, 1)));
            chk($sformatf("row%0d stall", i), 64'(stall), 64'(tbl[i].st));
            chk($sformatf("row%0d cnt", i), 64'(stall_cnt), 64'(tbl[i].cnt));
            chk($sformatf("row%0d cnt_sat", i), 64'(stall_cnt2), 64'(tbl[i].cnt[CW2-1:0]));
            @(posedge clk); #1;
        end

        // Self-dependent load repeatedly: stall every other cycle
        clrn = 1'b0;
        #2;
        chk_reset_outputs("reset2");
        @(posedge clk); #1;
        clrn = 1'b1;
        lw5 = mk(5, 0, 2'b01, 1, 1, 1, 5, 0, 0, 0, 0, 0);
        drive(lw5, 50);
        for (int i = 0; i <= 40; i++) begin
            #2;
            chk($sformatf("sat cyc%0d stall", i), 64'(stall), 64'(i % 2 == 1));
            @(posedge clk); #1;
        end
        chk("sat cnt16", 64'(stall_cnt), 64'(20));
        chk("sat cnt4", 64'(stall_cnt2), 64'(4'hF));

        // Reset asserted mid-stall drops everything before the next edge
        #2;
        chk("midstall stall", 64'(stall), 64'(1));
        clrn = 1'b0;
        #1;
        chk_reset_outputs("midstall rst");
        @(posedge clk); #1;
        clrn = 1'b1;
        #2;
        chk("post rst stall", 64'(stall), 64'(0));
        @(posedge clk); #1;
        #2;
        chk("post rst restall", 64'(stall), 64'(1));
        chk("post rst cnt", 64'(stall_cnt), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/operand_fwd_unit.md
OPERAND_FWD_UNIT -- requirements
Module: operand_fwd_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter REG_AW, default 5, register address width.
REQ-003 SHALL have parameter NUM_SRC, default 2, number of source operands forwarded per instruction.
REQ-004 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-005 SHALL have ports, one per line:
clk  input  1  single clock; all state on rising edge
clrn  input  1  reset; asynchronous, active-low
id_valid  input  1  ID-stage instruction valid
id_rs  input  NUM_SRC*REG_AW  source register numbers, src k at [k*REG_AW +: REG_AW]
id_rs_used  input  NUM_SRC  src k actually read by instruction
id_wreg  input  1  ID instruction writes a register
id_m2reg  input  1  ID instruction is a load
id_rd  input  REG_AW  ID destination register
flush  input  1  kill ID instruction (branch taken)
qa  input  NUM_SRC*DATA_W  register-file read data per src
ex_r  input  DATA_W  ALU result of EX-stage instruction
mem_r  input  DATA_W  ALU result held in EX/MEM
mem_mdo  input  DATA_W  data-memory output for MEM-stage load
fwd_o  output  NUM_SRC*DATA_W  forwarded operand per src
fwd_sel  output  NUM_SRC*2  per-src select: 0 qa, 1 ex_r, 2 mem_r, 3 mem_mdo
stall  output  1  load-use stall, hold PC and IF/ID
stall_cnt  output  CNT_W  saturating count of stall cycles

Function
REQ-006 SHALL keep internal stage records EX and MEM, each {valid, wreg, m2reg, rd}.
REQ-007 Each rising edge SHALL shift EX into MEM and load EX from the ID inputs; EX.valid = id_valid & ~stall & ~flush (bubble otherwise).
REQ-008 Per src k, fwd_sel SHALL be combinational from current state and ID inputs, priority order: EX hit (EX.valid & EX.wreg & ~EX.m2reg & EX.rd==rs_k) -> 1; MEM hit (MEM.valid & MEM.wreg & MEM.rd==rs_k) -> 3 if MEM.m2reg else 2; otherwise 0.
REQ-009 Register 0 SHALL never be forwarded: rs_k==0 forces select 0.
REQ-010 src k with id_rs_used[k]=0 SHALL select 0 and never cause stall.
REQ-011 fwd_o[k] SHALL equal the input chosen by fwd_sel[k] in the same cycle (zero latency mux).
REQ-012 stall SHALL be 1 when id_valid & ~flush & EX.valid & EX.wreg & EX.m2reg & EX.rd!=0 and some used rs_k==EX.rd; otherwise 0.
REQ-013 A load-use stall SHALL last exactly one cycle: the inserted bubble clears the EX hit, after which the load sits in MEM and select 3 applies.
REQ-014 flush SHALL take precedence over stall: stall=0 and a bubble enters EX.
REQ-015 When EX and MEM both hit the same register, EX SHALL win (youngest producer).
REQ-016 stall_cnt SHALL increment by 1 on each clock with stall=1 and saturate at all-ones (no wrap).
REQ-017 fwd_sel and stall SHALL depend only on state and ID inputs, never on data inputs.

Reset
REQ-018 While clrn=0, EX.valid, MEM.valid and stall_cnt SHALL be 0 asynchronously; other record fields 0.
REQ-019 Out of reset, stall=0 and fwd_sel=0 for all src, so fwd_o=qa.
REQ-020 Reset mid-stall SHALL drop stall immediately and discard in-flight records.

Structure
REQ-021 Select encodings (SEL_QA=0, SEL_EXR=1, SEL_MEMR=2, SEL_MDO=3) and default widths SHALL live in a shared package/include used with the CPU top.
REQ-022 One sub-module fwd_src_sel SHALL be instantiated NUM_SRC times (hazard compare plus 4:1 mux for one source); stage records and stall_cnt live in the parent.

Verification
REQ-023 add r3 then add r4,r3,r1 next cycle: fwd_sel src0=1, fwd_o src0=ex_r=0x00000011, stall=0.
REQ-024 lw r5 then add r6,r5,r5 next cycle: stall=1 for one cycle, stall_cnt 0->1, next cycle both srcs sel=3, fwd_o=mem_mdo=0xDEADBEEF.
REQ-025 Instructions writing r7 in EX and MEM, ID reads r7: sel=1 (EX wins); ID reads r0 with producers of r0: sel=0, fwd_o=qa.
REQ-026 Load in EX matching ID rs with flush=1: stall=0, next cycle EX.valid=0.
REQ-027 Force stall for 2^CNT_W+3 cycles: stall_cnt holds 0xFFFF; assert clrn=0 mid-stall: stall and stall_cnt 0 before next clock edge.
